ext_obi_addr_demux: RTL and testbench

- Parametrised, runtime-configurable OBI address demultiplexer for the external peripheral bus. It generalises the static external-peripheral address map to NumPorts programmable rules with per-rule enables.
- Tracks up to MaxTrans outstanding transactions and routes responses back in order.
- Answers unmapped accesses from an internal error responder, and reports them through a sticky interrupt, a captured address and a saturating counter.
- Sits between the MCU external-peripheral OBI master port and the external peripheral slaves.

---
 rtl/addr_map_rule_pkg.sv | 11 +
 rtl/ext_obi_demux_pkg.sv | 10 +
 rtl/ext_obi_demux_fifo.sv | 45 ++++
 rtl/ext_obi_addr_demux.sv | 156 +++++++++++++++
 tb/tb_ext_obi_addr_demux.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/addr_map_rule_pkg.sv
// Shared address-map rule type for the peripheral bus demultiplexers.
// A rule maps the half-open range [start_addr, end_addr) to port idx.
package addr_map_rule_pkg;

   typedef struct packed {
      logic [31:0] idx;
      logic [31:0] start_addr;
      logic [31:0] end_addr;
   } addr_map_rule_t;

endpackage

// File: rtl/ext_obi_demux_pkg.sv
// Constants and types for the external-peripheral OBI address demux.
// Error-log counter width, default error read data, map rule type.
package ext_obi_demux_pkg;

   localparam int unsigned ERR_COUNT_W = 16;
   localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADACCE5;

   typedef addr_map_rule_pkg::addr_map_rule_t addr_map_rule_t;

endpackage

// File: rtl/ext_obi_demux_fifo.sv
// Outstanding-transaction FIFO holding demux target indices.
// Ports: clk, rst (async high), push/wdata, pop, full, empty, head.
module ext_obi_demux_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [Width-1:0] wdata,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [Width-1:0] head
);

   localparam int unsigned AW = $clog2(Depth);

   logic [Width-1:0] mem [Depth];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;

   // Extra pointer bit distinguishes full from empty.
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) &&
                  (wptr[AW-1:0] == rptr[AW-1:0]);
   assign head  = mem[rptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

   // When full, a push only happens together with a pop, so
   // overwriting the head slot is safe: it is consumed this cycle.
   always_ff @(posedge clk) begin
      if (push) mem[wptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/ext_obi_addr_demux.sv
// Runtime-configurable OBI address demux with in-order responses and
// an internal error responder for unmapped accesses.
// Ports: clk_i, rst_i; addr_map_i/map_en_i rule table; m_* master side;
// s_* slave side; err_irq_o/err_addr_o/err_count_o log, err_clear_i.
module ext_obi_addr_demux
   import ext_obi_demux_pkg::*;
#(
   parameter int unsigned          NumPorts  = 4,
   parameter int unsigned          MaxTrans  = 4,
   parameter int unsigned          DataWidth = 32,
   parameter logic [DataWidth-1:0] ErrRdata  = DataWidth'(ERR_RDATA_DEFAULT)
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  addr_map_rule_t [NumPorts-1:0]       addr_map_i,
   input  logic [NumPorts-1:0]                 map_en_i,
   input  logic                                m_req_i,
   output logic                                m_gnt_o,
   input  logic [31:0]                         m_addr_i,
   input  logic                                m_we_i,
   input  logic [DataWidth/8-1:0]              m_be_i,
   input  logic [DataWidth-1:0]                m_wdata_i,
   output logic                                m_rvalid_o,
   output logic [DataWidth-1:0]                m_rdata_o,
   output logic [NumPorts-1:0]                 s_req_o,
   input  logic [NumPorts-1:0]                 s_gnt_i,
   output logic [31:0]                         s_addr_o,
   output logic                                s_we_o,
   output logic [DataWidth/8-1:0]              s_be_o,
   output logic [DataWidth-1:0]                s_wdata_o,
   input  logic [NumPorts-1:0]                 s_rvalid_i,
   input  logic [NumPorts-1:0][DataWidth-1:0]  s_rdata_i,
   output logic                                err_irq_o,
   output logic [31:0]                         err_addr_o,
   output logic [ERR_COUNT_W-1:0]              err_count_o,
   input  logic                                err_clear_i
);

   localparam int unsigned     IdxW   = $clog2(NumPorts + 1);
   localparam logic [IdxW-1:0] ErrIdx = IdxW'(NumPorts);

   logic [IdxW-1:0] tgt;
   logic [IdxW-1:0] last_tgt;
   logic [IdxW-1:0] head;
   logic            full;
   logic            empty;
   logic            push;
   logic            pop;
   logic            issue_ok;
   logic            err_tgt;
   logic            err_grant;
   logic            err_valid;

   // Descending scan so the lowest matching rule is assigned last.
   always_comb begin
      tgt = ErrIdx;
      for (int k = int'(NumPorts) - 1; k >= 0; k--) begin
         if (map_en_i[k] &&
             addr_map_i[k].idx < 32'(NumPorts) &&
             m_addr_i >= addr_map_i[k].start_addr &&
             m_addr_i <  addr_map_i[k].end_addr)
            tgt = IdxW'(addr_map_i[k].idx);
      end
   end

   assign err_tgt = (tgt == ErrIdx);

   // Only one target may be outstanding at a time, which keeps
   // responses in issue order without any reorder buffer.
   assign issue_ok = (!full || pop) && (empty || tgt == last_tgt);

   always_comb begin
      s_req_o = '0;
      for (int k = 0; k < int'(NumPorts); k++) begin
         if (tgt == IdxW'(k))
            s_req_o[k] = m_req_i && issue_ok && !rst_i;
      end
   end

   assign m_gnt_o = !rst_i &&
                    (err_tgt ? (m_req_i && issue_ok)
                             : |(s_req_o & s_gnt_i));

   assign s_addr_o  = m_addr_i;
   assign s_we_o    = m_we_i;
   assign s_be_o    = m_be_i;
   assign s_wdata_o = m_wdata_i;

   assign push      = m_req_i && m_gnt_o;
   assign err_grant = push && err_tgt;

   // Only the head target may answer; anything else is dropped.
   always_comb begin
      m_rvalid_o = 1'b0;
      m_rdata_o  = '0;
      if (!empty && !rst_i) begin
         if (head == ErrIdx) begin
            m_rvalid_o = err_valid;
            if (err_valid) m_rdata_o = ErrRdata;
         end else begin
            for (int k = 0; k < int'(NumPorts); k++) begin
               if (head == IdxW'(k) && s_rvalid_i[k]) begin
                  m_rvalid_o = 1'b1;
                  m_rdata_o  = s_rdata_i[k];
               end
            end
         end
      end
   end

   assign pop = m_rvalid_o;

   ext_obi_demux_fifo #(
      .Depth (MaxTrans),
      .Width (IdxW)
   ) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (push),
      .wdata (tgt),
      .pop   (pop),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         last_tgt    <= '0;
         err_valid   <= 1'b0;
         err_irq_o   <= 1'b0;
         err_addr_o  <= '0;
         err_count_o <= '0;
      end else begin
         if (push) last_tgt <= tgt;
         err_valid <= err_grant;
         // A new error beats a coincident clear.
         if (err_grant) begin
            err_irq_o <= 1'b1;
            if (err_clear_i) begin
               err_count_o <= ERR_COUNT_W'(1);
               err_addr_o  <= m_addr_i;
            end else begin
               if (!err_irq_o) err_addr_o <= m_addr_i;
               if (err_count_o != '1)
                  err_count_o <= err_count_o + ERR_COUNT_W'(1);
            end
         end else if (err_clear_i) begin
            err_irq_o   <= 1'b0;
            err_addr_o  <= '0;
            err_count_o <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ext_obi_addr_demux.sv
// Self-checking bench for ext_obi_addr_demux: decode vectors, directed
// multi-cycle sequences and a randomized run against a queue model.
module tb_ext_obi_addr_demux;
   import addr_map_rule_pkg::*;

   localparam logic [31:0] B   = 32'h3000_0000;
   localparam logic [31:0] ERR = 32'hBADACCE5;

   logic                  clk = 1'b0;
   logic                  rst;
   addr_map_rule_t [3:0]  map;
   logic [3:0]            map_en;
   logic                  m_req;
   logic                  m_gnt;
   logic [31:0]           m_addr;
   logic                  m_we;
   logic [3:0]            m_be;
   logic [31:0]           m_wdata;
   logic                  m_rvalid;
   logic [31:0]           m_rdata;
   logic [3:0]            s_req;
   logic [3:0]            s_gnt;
   logic [31:0]           s_addr;
   logic                  s_we;
   logic [3:0]            s_be;
   logic [31:0]           s_wdata;
   logic [3:0]            s_rvalid;
   logic [3:0][31:0]      s_rdata;
   logic                  err_irq;
   logic [31:0]           err_addr;
   logic [15:0]           err_count;
   logic                  err_clear;

   int nchk = 0;
   int nerr = 0;

   ext_obi_addr_demux #(
      .NumPorts  (4),
      .MaxTrans  (4),
      .DataWidth (32),
      .ErrRdata  (32'hBADACCE5)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .addr_map_i  (map),
      .map_en_i    (map_en),
      .m_req_i     (m_req),
      .m_gnt_o     (m_gnt),
      .m_addr_i    (m_addr),
      .m_we_i      (m_we),
      .m_be_i      (m_be),
      .m_wdata_i   (m_wdata),
      .m_rvalid_o  (m_rvalid),
      .m_rdata_o   (m_rdata),
      .s_req_o     (s_req),
      .s_gnt_i     (s_gnt),
      .s_addr_o    (s_addr),
      .s_we_o      (s_we),
      .s_be_o      (s_be),
      .s_wdata_o   (s_wdata),
      .s_rvalid_i  (s_rvalid),
      .s_rdata_i   (s_rdata),
      .err_irq_o   (err_irq),
      .err_addr_o  (err_addr),
      .err_count_o (err_count),
      .err_clear_i (err_clear)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          v;
      logic [3:0]  en;
      logic [31:0] addr;
      logic [3:0]  sreq;
      logic        gnt;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_map(input int v);
      map[0] = '{32'd0, B,             B + 32'h10};
      map[1] = '{32'd1, B + 32'h1000, B + 32'h1100};
      map[2] = '{32'd2, B + 32'h2000, B + 32'h2100};
      map[3] = '{32'd3, B + 32'h3000, B + 32'h3100};
      if (v == 1) map[1] = '{32'd1, B, B + 32'h10};
      if (v == 2) begin
         map[0].idx = 32'd7;
         map[1] = '{32'd1, B, B + 32'h10};
      end
      if (v == 3) map[0].idx = 32'd2;
   endtask

   function automatic int ref_tgt(input logic [31:0] a);
      for (int k = 0; k < 4; k++) begin
         if (map_en[k] && map[k].idx < 32'd4 &&
             a >= map[k].start_addr && a < map[k].end_addr)
            return int'(map[k].idx);
      end
      return 4;
   endfunction

   // model state for the randomized run
   int          q[$];
   int          pend[4];
   bit          err_pend;
   bit          mirq;
   logic [31:0] maddr;
   int          mcnt;

   initial begin
      int          t;
      bit          allow;
      bit          eg;
      bit          ev;
      logic [31:0] ed;
      logic [3:0]  es;
      int unsigned r;

      rst = 1'b1;
      set_map(0);
      map_en    = 4'hF;
      m_req     = 1'b1;
      m_addr    = B + 32'h5000;
      m_we      = 1'b0;
      m_be      = 4'hF;
      m_wdata   = '0;
      s_gnt     = 4'hF;
      s_rvalid  = 4'hF;
      s_rdata   = '0;
      err_clear = 1'b0;

      cyc();
      #2;
      chk("rst_gnt", m_gnt, 0);
      chk("rst_sreq", s_req, 0);
      chk("rst_rvalid", m_rvalid, 0);
      chk("rst_irq", err_irq, 0);
      chk("rst_eaddr", err_addr, 0);
      chk("rst_ecnt", err_count, 0);
      m_req = 1'b0;
      s_rvalid = '0;
      s_gnt = '0;
      cyc();
      rst = 1'b0;

      // decode vectors: slaves never grant, req dropped before the edge
      tbl.push_back('{0, 4'hF, B,                4'b0001, 1'b0});
      tbl.push_back('{0, 4'hF, B + 32'hF,        4'b0001, 1'b0});
      tbl.push_back('{0, 4'hF, B + 32'h10,       4'b0000, 1'b1});
      tbl.push_back('{0, 4'hF, B + 32'h1004,     4'b0010, 1'b0});
      tbl.push_back('{0, 4'hF, B + 32'h10FF,     4'b0010, 1'b0});
      tbl.push_back('{0, 4'hF, B + 32'h1100,     4'b0000, 1'b1});
      tbl.push_back('{0, 4'hF, B + 32'h3000,     4'b1000, 1'b0});
      tbl.push_back('{0, 4'hF, B + 32'h5000,     4'b0000, 1'b1});
      tbl.push_back('{0, 4'hF, 32'h2FFF_FFFF,    4'b0000, 1'b1});
      tbl.push_back('{0, 4'b1101, B + 32'h1000,  4'b0000, 1'b1});
      tbl.push_back('{0, 4'b1110, B + 32'h4,     4'b0000, 1'b1});
      tbl.push_back('{1, 4'hF, B + 32'h4,        4'b0001, 1'b0});
      tbl.push_back('{1, 4'b1110, B + 32'h4,     4'b0010, 1'b0});
      tbl.push_back('{2, 4'hF, B + 32'h4,        4'b0010, 1'b0});
      tbl.push_back('{3, 4'hF, B + 32'h4,        4'b0100, 1'b0});

      foreach (tbl[i]) begin
         cyc();
         set_map(tbl[i].v);
         map_en = tbl[i].en;
         m_addr = tbl[i].addr;
         m_req  = 1'b1;
         #2;
         chk($sformatf("vec%0d_sreq", i), s_req, tbl[i].sreq);
         chk($sformatf("vec%0d_gnt", i), m_gnt, tbl[i].gnt);
         chk($sformatf("vec%0d_saddr", i), s_addr, tbl[i].addr);
         m_req = 1'b0;
      end
      set_map(0);
      map_en = 4'hF;
      s_gnt  = 4'hF;

      // single read to port 1, response after 3 cycles
      cyc();
      m_req = 1'b1; m_addr = B + 32'h1004;
      #2;
      chk("s1_sreq", s_req, 4'b0010);
      chk("s1_gnt", m_gnt, 1);
      cyc();
      m_req = 1'b0;
      #2 chk("s1_wait", m_rvalid, 0);
      cyc();
      cyc();
      s_rvalid = 4'b0010; s_rdata[1] = 32'h1234;
      #2;
      chk("s1_rvalid", m_rvalid, 1);
      chk("s1_rdata", m_rdata, 32'h1234);
      cyc();
      #2 chk("s1_drop", m_rvalid, 0);
      s_rvalid = '0;
      m_req = 1'b1; m_addr = B + 32'h3000;
      #1;
      chk("s1_empty_gnt", m_gnt, 1);
      cyc();
      m_req = 1'b0;
      s_rvalid = 4'b1000; s_rdata[3] = 32'h3333;
      #2 chk("s1_p3_rdata", m_rdata, 32'h3333);
      cyc();
      s_rvalid = '0;

      // four reads to port 2 fill the FIFO; fifth stalls
      for (int i = 0; i < 4; i++) begin
         m_req = 1'b1; m_addr = B + 32'h2000 + 32'(4 * i);
         #2 chk($sformatf("s2_gnt%0d", i), m_gnt, 1);
         cyc();
      end
      m_addr = B + 32'h2010;
      #2;
      chk("s2_full_gnt", m_gnt, 0);
      chk("s2_full_sreq", s_req, 0);
      cyc();
      s_rvalid = 4'b0100; s_rdata[2] = 32'hA0;
      #2;
      chk("s2_rv0", m_rvalid, 1);
      chk("s2_rd0", m_rdata, 32'hA0);
      chk("s2_pop_push_gnt", m_gnt, 1);
      cyc();
      m_req = 1'b0;
      for (int i = 1; i < 5; i++) begin
         s_rdata[2] = 32'hA0 + 32'(i);
         #2;
         chk($sformatf("s2_rv%0d", i), m_rvalid, 1);
         chk($sformatf("s2_rd%0d", i), m_rdata, 32'hA0 + 32'(i));
         cyc();
      end
      #2 chk("s2_drained", m_rvalid, 0);
      s_rvalid = '0;

      // port 0 then port 3: second waits for the first response
      cyc();
      m_req = 1'b1; m_addr = B;
      #2 chk("s3_p0_gnt", m_gnt, 1);
      cyc();
      m_addr = B + 32'h3000;
      s_rvalid = 4'b0100;
      #2;
      chk("s3_block_gnt", m_gnt, 0);
      chk("s3_block_sreq", s_req, 0);
      chk("s3_nonhead_drop", m_rvalid, 0);
      cyc();
      s_rvalid = 4'b0001; s_rdata[0] = 32'h55;
      #2;
      chk("s3_rv0", m_rvalid, 1);
      chk("s3_rd0", m_rdata, 32'h55);
      chk("s3_still_block", m_gnt, 0);
      cyc();
      s_rvalid = '0;
      #2;
      chk("s3_p3_gnt", m_gnt, 1);
      chk("s3_p3_sreq", s_req, 4'b1000);
      cyc();
      m_req = 1'b0;
      s_rvalid = 4'b1000; s_rdata[3] = 32'h77;
      #2 chk("s3_rd3", m_rdata, 32'h77);
      cyc();
      s_rvalid = '0;

      // error responder and error log
      m_req = 1'b1; m_addr = B + 32'h5000; m_we = 1'b1;
      #2;
      chk("s4_gnt", m_gnt, 1);
      chk("s4_sreq", s_req, 0);
      cyc();
      m_req = 1'b0; m_we = 1'b0;
      #2;
      chk("s4_rv", m_rvalid, 1);
      chk("s4_rd", m_rdata, ERR);
      chk("s4_irq", err_irq, 1);
      chk("s4_eaddr", err_addr, B + 32'h5000);
      chk("s4_cnt1", err_count, 1);
      cyc();
      m_req = 1'b1; m_addr = B + 32'h6000;
      #2 chk("s4_gnt2", m_gnt, 1);
      cyc();
      m_addr = B + 32'h7000;
      #2;
      chk("s4_b2b_rv", m_rvalid, 1);
      chk("s4_b2b_gnt", m_gnt, 1);
      chk("s4_eaddr_keep", err_addr, B + 32'h5000);
      chk("s4_cnt2", err_count, 2);
      cyc();
      m_addr = B + 32'h8000; err_clear = 1'b1;
      #2;
      chk("s4_b2b_rv2", m_rvalid, 1);
      chk("s4_cnt3", err_count, 3);
      cyc();
      m_req = 1'b0; err_clear = 1'b0;
      #2;
      chk("s4_clr_rv", m_rvalid, 1);
      chk("s4_clr_cnt", err_count, 1);
      chk("s4_clr_eaddr", err_addr, B + 32'h8000);
      chk("s4_clr_irq", err_irq, 1);
      cyc();
      #2 chk("s4_idle", m_rvalid, 0);

      // reset with two port-1 reads outstanding
      cyc();
      m_req = 1'b1; m_addr = B + 32'h1000;
      #2 chk("s5_gnt0", m_gnt, 1);
      cyc();
      m_addr = B + 32'h1004;
      #2 chk("s5_gnt1", m_gnt, 1);
      cyc();
      m_addr = B + 32'h1008;
      s_rvalid = 4'b0010; s_rdata[1] = 32'h99;
      rst = 1'b1;
      #1;
      chk("s5_rst_gnt", m_gnt, 0);
      chk("s5_rst_sreq", s_req, 0);
      chk("s5_rst_rv", m_rvalid, 0);
      chk("s5_rst_irq", err_irq, 0);
      chk("s5_rst_eaddr", err_addr, 0);
      chk("s5_rst_cnt", err_count, 0);
      cyc();
      rst = 1'b0; m_req = 1'b0;
      #2 chk("s5_late_rv0", m_rvalid, 0);
      cyc();
      #2;
      chk("s5_late_rv1", m_rvalid, 0);
      chk("s5_late_rd1", m_rdata, 0);
      cyc();
      s_rvalid = '0;
      m_req = 1'b1; m_addr = B + 32'h3000;
      #2 chk("s5_empty_gnt", m_gnt, 1);
      cyc();
      m_req = 1'b0;
      s_rvalid = 4'b1000; s_rdata[3] = 32'h3;
      #2 chk("s5_rv3", m_rvalid, 1);
      cyc();
      s_rvalid = '0;

      // randomized run against the queue model
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      q.delete();
      pend = '{0, 0, 0, 0};
      err_pend = 0;
      mirq = 0;
      maddr = '0;
      mcnt = 0;
      for (int n = 0; n < 400; n++) begin
         cyc();
         m_req = ($urandom % 4) != 0;
         r = $urandom % 7;
         m_addr = (r == 6) ? B - 32'd4
                           : B + 32'(r << 12) + 32'($urandom % 32'h120);
         m_we = 1'($urandom);
         m_be = 4'($urandom);
         m_wdata = $urandom;
         s_gnt = 4'($urandom);
         for (int p = 0; p < 4; p++) begin
            s_rvalid[p] = (pend[p] > 0) ? 1'($urandom)
                                        : (($urandom % 8) == 0);
            s_rdata[p] = $urandom;
         end
         err_clear = ($urandom % 16) == 0;
         if (($urandom % 32) == 0) map_en = 4'($urandom);
         #2;
         t = ref_tgt(m_addr);
         ev = 0;
         ed = '0;
         if (q.size() > 0) begin
            if (q[0] == 4) ev = err_pend;
            else ev = s_rvalid[q[0]];
            if (ev) ed = (q[0] == 4) ? ERR : s_rdata[q[0]];
         end
         allow = (q.size() < 4 || ev) && (q.size() == 0 || q[$] == t);
         es = (m_req && allow && t < 4) ? 4'(1 << t) : 4'b0;
         eg = m_req && allow && (t == 4 || s_gnt[t]);
         chk($sformatf("r%0d_rv", n), m_rvalid, ev);
         chk($sformatf("r%0d_rd", n), m_rdata, ed);
         chk($sformatf("r%0d_sreq", n), s_req, es);
         chk($sformatf("r%0d_gnt", n), m_gnt, eg);
         chk($sformatf("r%0d_irq", n), err_irq, mirq);
         chk($sformatf("r%0d_eaddr", n), err_addr, maddr);
         chk($sformatf("r%0d_cnt", n), err_count, mcnt);
         chk($sformatf("r%0d_pass", n), {s_we, s_be, s_wdata},
             {m_we, m_be, m_wdata});
         if (ev) void'(q.pop_front());
         for (int p = 0; p < 4; p++)
            if (s_rvalid[p] && pend[p] > 0) pend[p]--;
         if (eg) begin
            q.push_back(t);
            if (t < 4) pend[t]++;
         end
         err_pend = eg && t == 4;
         if (eg && t == 4) begin
            if (err_clear) begin
               mcnt = 1;
               maddr = m_addr;
            end else begin
               if (!mirq) maddr = m_addr;
               if (mcnt < 65535) mcnt++;
            end
            mirq = 1;
         end else if (err_clear) begin
            mirq = 0;
            maddr = '0;
            mcnt = 0;
         end
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
